// File: rtl/ctrl_pipe_decoder_if.sv
// Handshake and result bundle between instruction fetch, the pipelined
// control decoder and the execute stage.
`timescale 1ns/1ps
interface ctrl_pipe_decoder_if #(
   parameter int MCODEBITS = 9,
   parameter int REGW      = 2,
   parameter int OPWIDTH   = 3,
   parameter int CNTW      = 16
);
   logic [MCODEBITS-1:0] in_instr;
   logic                 in_valid;
   logic                 in_ready;
   logic                 flush;
   logic                 out_ready;
   logic                 out_valid;
   logic                 branch;
   logic                 memtoreg;
   logic                 memwrite;
   logic                 alusrc;
   logic                 regwrite;
   logic [OPWIDTH-1:0]   aluop;
   logic [REGW-1:0]      out_ra;
   logic [REGW-1:0]      out_rb;
   logic                 illegal;
   logic                 illegal_seen;
   logic [CNTW-1:0]      retire_cnt;
   logic [CNTW-1:0]      stall_cnt;

   // Fetch/execute side: supplies instructions and consumes decoded results.
   modport master (
      output in_instr, in_valid, flush, out_ready,
      input  in_ready, out_valid, branch, memtoreg, memwrite, alusrc, regwrite,
             aluop, out_ra, out_rb, illegal, illegal_seen, retire_cnt, stall_cnt
   );

   // Decoder side.
   modport slave (
      input  in_instr, in_valid, flush, out_ready,
      output in_ready, out_valid, branch, memtoreg, memwrite, alusrc, regwrite,
             aluop, out_ra, out_rb, illegal, illegal_seen, retire_cnt, stall_cnt
   );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// Registered control decoder with valid/ready flow control, load-use interlock,
// branch flush, illegal-opcode detection and saturating performance counters.
`timescale 1ns/1ps
module ctrl_pipe_decoder #(
   parameter int MCODEBITS = 9,
   parameter int OPBITS    = 4,
   parameter int REGW      = 2,
   parameter int OPWIDTH   = 3,
   parameter int CNTW      = 16
) (
   input logic               clk,
   input logic               rst_n,
   ctrl_pipe_decoder_if.slave bus
);
   localparam logic [OPBITS-1:0] OP_LOAD   = OPBITS'(0);
   localparam logic [OPBITS-1:0] OP_STORE  = OPBITS'(1);
   localparam logic [OPBITS-1:0] OP_XOR    = OPBITS'(2);
   localparam logic [OPBITS-1:0] OP_BNE    = OPBITS'(3);
   localparam logic [OPBITS-1:0] OP_ADD    = OPBITS'(4);
   localparam logic [OPBITS-1:0] OP_MOV    = OPBITS'(5);
   localparam logic [OPBITS-1:0] OP_LSHIFT = OPBITS'(6);
   localparam logic [OPBITS-1:0] OP_RSHIFT = OPBITS'(7);
   localparam logic [OPBITS-1:0] OP_LOADI  = OPBITS'(8);

   logic [OPBITS-1:0]  opcode;
   logic [REGW-1:0]    inRa;
   logic [REGW-1:0]    inRb;
   logic               unusedInstrBits;

   logic               decBranch, decMemtoreg, decMemwrite, decAlusrc, decRegwrite, decIllegal;
   logic [OPWIDTH-1:0] decAluop;
   logic               readsRa, readsRb;
   logic               advance, hazard, accept;

   assign opcode = bus.in_instr[MCODEBITS-1 -: OPBITS];
   assign inRa   = bus.in_instr[MCODEBITS-OPBITS-1 -: REGW];
   assign inRb   = bus.in_instr[MCODEBITS-OPBITS-REGW-1 -: REGW];
   assign unusedInstrBits = ^bus.in_instr;

   // Decode table plus the source-register usage the interlock needs.
   always_comb begin
      decAluop    = '1;
      decBranch   = 1'b0;
      decMemtoreg = 1'b0;
      decMemwrite = 1'b0;
      decAlusrc   = 1'b0;
      decRegwrite = 1'b1;
      decIllegal  = 1'b0;
      readsRa     = 1'b1;
      readsRb     = 1'b1;
      case (opcode)
         OP_LOAD:   decMemtoreg = 1'b1;
         OP_STORE:  begin decMemwrite = 1'b1; decRegwrite = 1'b0; end
         OP_XOR:    decAluop = OPWIDTH'(1);
         OP_BNE:    begin decAluop = OPWIDTH'(2); decBranch = 1'b1; decRegwrite = 1'b0; end
         OP_ADD:    decAluop = OPWIDTH'(3);
         OP_MOV:    decAluop = '1;
         OP_LSHIFT: begin decAluop = OPWIDTH'(4); decAlusrc = 1'b1; readsRb = 1'b0; end
         OP_RSHIFT: begin decAluop = OPWIDTH'(5); decAlusrc = 1'b1; readsRb = 1'b0; end
         OP_LOADI:  begin decAluop = OPWIDTH'(6); decAlusrc = 1'b1; readsRa = 1'b0; readsRb = 1'b0; end
         default:   begin decRegwrite = 1'b0; decIllegal = 1'b1; end
      endcase
   end

   // A load sitting in the output register writes out_ra; a consumer of that
   // register must wait one cycle for the load to leave.
   assign advance = !bus.out_valid || bus.out_ready;
   assign hazard  = bus.out_valid && bus.memtoreg && bus.in_valid &&
                    ((readsRa && (inRa == bus.out_ra)) || (readsRb && (inRb == bus.out_ra)));
   assign bus.in_ready = advance && !hazard && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid    <= 1'b0;
         bus.branch       <= 1'b0;
         bus.memtoreg     <= 1'b0;
         bus.memwrite     <= 1'b0;
         bus.alusrc       <= 1'b0;
         bus.regwrite     <= 1'b0;
         bus.aluop        <= '1;
         bus.out_ra       <= '0;
         bus.out_rb       <= '0;
         bus.illegal      <= 1'b0;
         bus.illegal_seen <= 1'b0;
      end else begin
         if (bus.flush) begin
            bus.out_valid <= 1'b0;
         end else if (advance) begin
            bus.out_valid <= bus.in_valid && !hazard;
         end
         if (accept) begin
            bus.branch   <= decBranch;
            bus.memtoreg <= decMemtoreg;
            bus.memwrite <= decMemwrite;
            bus.alusrc   <= decAlusrc;
            bus.regwrite <= decRegwrite;
            bus.aluop    <= decAluop;
            bus.out_ra   <= inRa;
            bus.out_rb   <= inRb;
            bus.illegal  <= decIllegal;
            if (decIllegal) begin
               bus.illegal_seen <= 1'b1;
            end
         end
      end
   end

   // Retirement still counts when a flush lands on the same handshake cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.retire_cnt <= '0;
         bus.stall_cnt  <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready && (bus.retire_cnt != '1)) begin
            bus.retire_cnt <= bus.retire_cnt + CNTW'(1);
         end
         if (bus.in_valid && !bus.in_ready && (bus.stall_cnt != '1)) begin
            bus.stall_cnt <= bus.stall_cnt + CNTW'(1);
         end
      end
   end
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Randomized bench for ctrl_pipe_decoder: a transaction-level model predicts
// every cycle's handshake and output register; a CNTW=2 copy checks saturation.
`timescale 1ns/1ps
module tb_ctrl_pipe_decoder;
   localparam int MCODEBITS = 9;
   localparam int OPBITS    = 4;
   localparam int REGW      = 2;
   localparam int OPWIDTH   = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Model state: what the output register should hold and the event counts.
   logic       mValid;
   logic [8:0] mCtl;
   logic [1:0] mRa, mRb;
   logic       mSeen;
   int         mRetire, mStall;

   always #5 clk = ~clk;

   ctrl_pipe_decoder_if #(.MCODEBITS(MCODEBITS), .REGW(REGW), .OPWIDTH(OPWIDTH), .CNTW(16)) bus ();
   ctrl_pipe_decoder_if #(.MCODEBITS(MCODEBITS), .REGW(REGW), .OPWIDTH(OPWIDTH), .CNTW(2)) busSmall ();

   assign busSmall.in_instr  = bus.in_instr;
   assign busSmall.in_valid  = bus.in_valid;
   assign busSmall.flush     = bus.flush;
   assign busSmall.out_ready = bus.out_ready;

   ctrl_pipe_decoder #(.MCODEBITS(MCODEBITS), .OPBITS(OPBITS), .REGW(REGW), .OPWIDTH(OPWIDTH), .CNTW(16))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   ctrl_pipe_decoder #(.MCODEBITS(MCODEBITS), .OPBITS(OPBITS), .REGW(REGW), .OPWIDTH(OPWIDTH), .CNTW(2))
      dutSmall (.clk(clk), .rst_n(rst_n), .bus(busSmall.slave));

   // Packed as {branch, memtoreg, memwrite, alusrc, regwrite, aluop, illegal}.
   function automatic logic [8:0] expectCtl(input logic [3:0] op);
      case (op)
         4'd0:    return 9'b0_1_0_0_1_111_0;
         4'd1:    return 9'b0_0_1_0_0_111_0;
         4'd2:    return 9'b0_0_0_0_1_001_0;
         4'd3:    return 9'b1_0_0_0_0_010_0;
         4'd4:    return 9'b0_0_0_0_1_011_0;
         4'd5:    return 9'b0_0_0_0_1_111_0;
         4'd6:    return 9'b0_0_0_1_1_100_0;
         4'd7:    return 9'b0_0_0_1_1_101_0;
         4'd8:    return 9'b0_0_0_1_1_110_0;
         default: return 9'b0_0_0_0_0_111_1;
      endcase
   endfunction

   function automatic bit readsReg(input logic [8:0] instr, input logic [1:0] r);
      logic [3:0] op;
      op = instr[8:5];
      if (op == 4'd8) return 1'b0;
      if (op == 4'd6 || op == 4'd7) return instr[4:3] == r;
      return (instr[4:3] == r) || (instr[2:1] == r);
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compareState();
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
      checkOutput("ctl", 32'({bus.branch, bus.memtoreg, bus.memwrite, bus.alusrc, bus.regwrite,
                              bus.aluop, bus.illegal}), 32'(mCtl));
      checkOutput("regs", 32'({bus.out_ra, bus.out_rb}), 32'({mRa, mRb}));
      checkOutput("illegal_seen", 32'(bus.illegal_seen), 32'(mSeen));
      checkOutput("retire_cnt", 32'(bus.retire_cnt), 32'(sat(mRetire, 65535)));
      checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(sat(mStall, 65535)));
      checkOutput("retire_sat", 32'(busSmall.retire_cnt), 32'(sat(mRetire, 3)));
      checkOutput("stall_sat", 32'(busSmall.stall_cnt), 32'(sat(mStall, 3)));
   endtask

   task automatic modelReset();
      mValid  = 1'b0;
      mCtl    = 9'b0_0_0_0_0_111_0;
      mRa     = 2'b00;
      mRb     = 2'b00;
      mSeen   = 1'b0;
      mRetire = 0;
      mStall  = 0;
   endtask

   // Holds reset with live traffic on the inputs; nothing may move.
   task automatic applyReset(input int cycles);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 9'($urandom);
      bus.out_ready = 1'b1;
      bus.flush     = 1'b0;
      modelReset();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         compareState();
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   // One clock of traffic: predict the handshake, check, then advance the model.
   task automatic applyStimulus(input logic v, input logic [8:0] ins, input logic ordy, input logic fl);
      bit hz, expRdy;
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.out_ready = ordy;
      bus.flush     = fl;
      hz     = mValid && (mCtl[8:0] == expectCtl(4'd0)) && v && readsReg(ins, mRa);
      expRdy = (!mValid || ordy) && !hz && !fl;
      @(negedge clk);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expRdy));
      compareState();
      @(posedge clk);
      if (mValid && ordy) mRetire++;
      if (v && !expRdy) mStall++;
      if (fl) begin
         mValid = 1'b0;
      end else if (!mValid || ordy) begin
         mValid = v && !hz;
         if (v && expRdy) begin
            mCtl = expectCtl(ins[8:5]);
            mRa  = ins[4:3];
            mRb  = ins[2:1];
            if (mCtl[0]) mSeen = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      logic [3:0] op;
      logic [8:0] ins;
      applyReset(3);
      checkOutput("rst_aluop", 32'(bus.aluop), 32'h7);
      checkOutput("rst_regwrite", 32'(bus.regwrite), 32'h0);

      // First add after reset, then the nine legal opcodes back to back.
      applyStimulus(1'b1, 9'b0100_01_10_0, 1'b1, 1'b0);
      checkOutput("first_add_aluop", 32'(bus.aluop), 32'h3);
      checkOutput("first_add_ra", 32'(bus.out_ra), 32'h1);
      for (int i = 0; i < 9; i++) begin
         op = 4'(i);
         applyStimulus(1'b1, (i == 0) ? 9'b0000_00_00_0 : {op, 4'b0101, 1'b0}, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
      checkOutput("stream_retire", 32'(bus.retire_cnt), 32'd10);
      checkOutput("stream_stall", 32'(bus.stall_cnt), 32'd0);
      checkOutput("stream_retire_sat", 32'(busSmall.retire_cnt), 32'd3);

      // Load-use with add (one bubble), then loadi as consumer (none).
      applyStimulus(1'b1, 9'b0000_10_00_0, 1'b1, 1'b0);
      applyStimulus(1'b1, 9'b0100_01_10_0, 1'b1, 1'b0);
      checkOutput("loaduse_bubble", 32'(bus.out_valid), 32'd0);
      applyStimulus(1'b1, 9'b0100_01_10_0, 1'b1, 1'b0);
      applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 9'b0000_10_00_0, 1'b1, 1'b0);
      applyStimulus(1'b1, 9'b1000_10_00_0, 1'b1, 1'b0);
      applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
      checkOutput("loaduse_stall", 32'(bus.stall_cnt), 32'd1);

      // Backpressure: xor held in the output register for three cycles.
      applyStimulus(1'b1, 9'b0010_11_01_0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 9'b0100_00_01_0, 1'b0, 1'b0);
      checkOutput("bp_stall", 32'(bus.stall_cnt), 32'd4);
      checkOutput("bp_aluop", 32'(bus.aluop), 32'h1);
      applyStimulus(1'b1, 9'b0100_00_01_0, 1'b1, 1'b0);

      // Flush with bne in the output register and add waiting at the input.
      applyStimulus(1'b1, 9'b0011_01_10_0, 1'b1, 1'b0);
      applyStimulus(1'b1, 9'b0100_01_10_0, 1'b1, 1'b1);
      checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
      applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);

      // Illegal opcode leaves a sticky mark.
      applyStimulus(1'b1, 9'b1011_01_01_0, 1'b1, 1'b0);
      checkOutput("illegal_flag", 32'(bus.illegal), 32'd1);
      applyStimulus(1'b1, 9'b0101_01_01_0, 1'b1, 1'b0);
      applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
      checkOutput("illegal_sticky", 32'(bus.illegal_seen), 32'd1);

      // Reset mid-stream drops the in-flight instruction.
      applyStimulus(1'b1, 9'b0100_10_10_0, 1'b0, 1'b0);
      applyReset(2);
      checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);

      // Random traffic with occasional flushes and resets.
      for (int n = 0; n < 600; n++) begin
         op  = 4'($urandom_range(0, 10));
         if (op > 4'd8) op = 4'($urandom_range(9, 15));
         ins = {op, 5'($urandom)};
         if ($urandom_range(0, 199) == 0) begin
            applyReset(1);
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 99) < 8);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_pipe_decoder.md
Name: ctrl_pipe_decoder

Overview:
- Registered, handshaked successor to the combinational control decoder.
- Decodes one instruction per cycle into a pipeline register that feeds the execute stage.
- Adds valid/ready flow control, a load-use interlock, branch flush, illegal-opcode detection and saturating performance counters.
- Sits between instruction fetch and the ALU/register-file/data-memory datapath.

Parameters:
- MCODEBITS, 9: instruction width.
- OPBITS, 4: opcode width, taken from instr[MCODEBITS-1 -: OPBITS].
- REGW, 2: register field width. ra = instr[MCODEBITS-OPBITS-1 -: REGW]; rb = the next REGW bits below ra.
- OPWIDTH, 3: ALUOp width.
- CNTW, 16: width of each performance counter.

Ports:
- Clk, input, 1: clock.
- Reset, input, 1: asynchronous, active-low reset.
- in_instr, input, MCODEBITS: instruction from fetch.
- in_valid, input, 1: in_instr is valid.
- in_ready, output, 1: decoder accepts in_instr this cycle.
- flush, input, 1: taken branch resolved downstream; kill in-flight work.
- out_ready, input, 1: execute stage accepts the output register.
- out_valid, output, 1: output register holds a valid decoded instruction.
- Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, output, 1 each: registered control flags.
- ALUOp, output, OPWIDTH: registered ALU operation.
- out_ra, out_rb, output, REGW each: registered register fields.
- illegal, output, 1: output instruction had an unassigned opcode.
- illegal_seen, output, 1: sticky flag; set on any accepted illegal opcode.
- retire_cnt, output, CNTW: count of out_valid && out_ready handshakes; saturates.
- stall_cnt, output, CNTW: count of cycles with in_valid && !in_ready; saturates.

Behaviour:
- Reset asserted (Reset=0, asynchronous):
  - out_valid=0, illegal=0, illegal_seen=0, counters=0.
  - Flags=0 except RegWrite=0; ALUOp=3'b111; out_ra=out_rb=0.
- Decode table. Opcode -> ALUOp / flags set; unlisted flags are 0; RegWrite=1 unless stated.
  - 0000 load: 111 / MemtoReg.
  - 0001 store: 111 / MemWrite, RegWrite=0.
  - 0010 xor: 001.
  - 0011 bne: 010 / Branch, RegWrite=0.
  - 0100 add: 011.
  - 0101 mov: 111.
  - 0110 lshift: 100 / ALUSrc.
  - 0111 rshift: 101 / ALUSrc.
  - 1000 loadi: 110 / ALUSrc.
  - Others (illegal): 111, RegWrite=0, illegal=1.
- Source registers for the hazard check:
  - ALUSrc=0 ops read ra and rb.
  - lshift/rshift read ra only.
  - loadi reads none.
- Destination register: ra, when RegWrite=1.
- Latency: exactly 1 cycle from an accepted input to out_valid.
- advance = !out_valid || out_ready.
- hazard = out_valid && MemtoReg && in_valid && the decoded input reads out_ra.
- in_ready = advance && !hazard && !flush.
- Each rising Clk, highest priority first:
  - flush=1: out_valid<=0; input not accepted.
  - else if advance: out_valid <= in_valid && !hazard. Fields load only on acceptance; when a bubble is inserted, fields hold their previous values.
  - else: output register holds, all fields stable (no change while out_valid && !out_ready).
- Load-use hazard costs exactly one bubble cycle. The next cycle the load has left, so the hazard clears and the instruction is accepted.
- A flush in the same cycle as an out_ready handshake still counts the retirement.
- illegal_seen sets on acceptance of an illegal opcode and clears only on reset.
- Counters stop at 2^CNTW-1; no wrap-around.
- Reset mid-stream drops the in-flight instruction; no output or counter update occurs until after Reset deasserts.

Test Plan:
- Reset: hold Reset=0 with in_valid=1 -> out_valid=0, ALUOp=111, RegWrite=0, counters 0. After release, first add (0100_01_10_0) -> next cycle out_valid=1, ALUOp=011, RegWrite=1, out_ra=01.
- Back-to-back decode: stream all nine legal opcodes with out_ready=1 -> one output per cycle matching the decode table; retire_cnt=9; stall_cnt=0.
- Load-use: load ra=10, then add ra=01 rb=10 -> one bubble (out_valid=0) then add; stall_cnt=1. Repeat with loadi as the consumer -> no bubble.
- Backpressure: out_ready=0 for 3 cycles with xor held -> outputs stable; in_ready=0; stall_cnt+=3; retire_cnt unchanged until out_ready=1.
- Flush: flush=1 while bne sits in output and add is at input -> next cycle out_valid=0; add not accepted; in_ready=0 during flush; retire_cnt increments if out_ready was 1.
- Illegal/saturation: opcode 1011 -> illegal=1, RegWrite=0, illegal_seen stays 1 afterwards. With CNTW=2, five retirements -> retire_cnt=3.
